db_target_resp: RTL and testbench
=================================

Name: db_target_resp

Overview:
Target-side (responder) endpoint logic for the doorbell/NWR self-check protocol.
- Accepts inbound target requests (treq) from the RapidIO logical layer.
- Answers doorbells with a doorbell response carrying ready/busy/ack info.
- Unpacks NWR packets into a simple write stream for user logic.
- Sits between the SRIO core treq/tresp AXI-Stream ports and the target buffer.

Parameters:
DEV_ID, 8'hF0, this endpoint's ID, placed in tresp_tuser_o[23:16].
MAX_BEATS, 32, maximum NWR payload beats (256 bytes) before overrun.

Ports:
log_clk  in  1  logic clock
log_rst  in  1  asynchronous active-high reset
treq_tvalid_in  in  1  request beat valid
treq_tready_o  out  1  request beat accept
treq_tlast_in  in  1  last beat of request packet
treq_tdata_in  in  64  HELLO header / payload
treq_tkeep_in  in  8  byte enables
treq_tuser_in  in  32  {src_id[15:0], dest_id[15:0]}
tresp_tvalid_o  out  1  response valid
tresp_tready_in  in  1  response accept
tresp_tlast_o  out  1  response last (always 1 when valid)
tresp_tdata_o  out  64  doorbell response header
tresp_tkeep_o  out  8  byte enables (8'hFF when valid)
tresp_tuser_o  out  32  {8'h00, DEV_ID, requester src_id[15:0]}
user_busy_in  in  1  target buffer cannot accept data
user_wr_valid_o  out  1  write beat valid
user_wr_addr_o  out  34  byte address of beat
user_wr_data_o  out  64  write data
user_wr_keep_o  out  8  write byte enables
user_wr_last_o  out  1  last beat of NWR packet
db_info_valid_o  out  1  one-cycle pulse: data-integration doorbell received
db_info_o  out  16  info of that doorbell (0x0200+n)
nwr_pkt_cnt_o  out  16  count of completed NWR packets, wraps at 0xFFFF->0
nwr_err_o  out  1  one-cycle pulse on NWR protocol error

Behaviour:
Header fields:
- tid [63:56], ftype [55:52], ttype [51:48], prio [46:45], size [43:36], addr [33:0], doorbell info [31:16].

Reset values:
- All outputs 0, except tresp_tkeep_o=0 and treq_tready_o=0 during reset.
- State IDLE, counters 0.

FSM states: IDLE, DB_RESP, NWR_DATA, DROP.

IDLE:
- treq_tready_o=1. A beat is a handshake (valid & ready).
- DOORB (4'hA) with tlast:
  - Latch tid, prio, info, treq_tuser_in[31:16].
  - Sample user_busy_in on the same cycle.
  - Go to DB_RESP.
- NWR (ftype 4'h5, ttype 4'h4) without tlast:
  - Latch addr into base.
  - Clear beat counter.
  - Go to NWR_DATA.
- Any other header:
  - With tlast, stay in IDLE.
  - Without tlast, go to DROP.
- NWR header with tlast (no payload): pulse nwr_err_o, stay in IDLE.

DB_RESP:
- treq_tready_o=0, which back-pressures any following request.
- tresp_tvalid_o=1, tlast=1, tkeep=FF.
- tdata = {tid, 4'hA, 4'h0, 1'b0, prio+1 (2-bit, wraps 3->0), 1'b0, 12'h0, resp_info, 16'h0}.
- resp_info:
  - Info 0x0101 (self-check): 0x0100 if not busy, 0x01FF if busy.
  - Info 0x0200-0x02FF: resp_info echoes info. db_info_o=info and db_info_valid_o pulses on the cycle DB_RESP is entered.
  - Any other info: 0x01FF.
- Hold all fields stable until tresp_tready_in, then deassert on the next cycle and go to IDLE.

NWR_DATA:
- treq_tready_o=1.
- Each beat is presented on user_wr_* exactly 1 cycle later (registered):
  - addr = base + 8*beat_idx (34-bit add, wraps).
  - data, keep and last are passed through from the beat.
- Beat counter width is 6 bits.
- On a tlast beat: nwr_pkt_cnt_o increments, go to IDLE.
- If a non-tlast beat is the MAX_BEATS-th payload beat: pulse nwr_err_o, go to DROP.
  - The overflowing beat is still written.
  - user_wr_last_o is forced to 1 on it.
- user_busy_in does not stall the payload; the user side must absorb 1 beat per cycle.

DROP:
- treq_tready_o=1, discard beats, go to IDLE on a tlast beat.

Other rules:
- Asynchronous reset mid-packet returns to IDLE immediately.
- A partial NWR is not counted, and no user_wr_last_o is emitted.
- A simultaneous treq beat and tresp handshake cannot occur, because tready=0 in DB_RESP.

Optional Feature:
NWR_SIZE_CHECK_EN
- Defined: on the tlast beat, compare beats received with expected = (size+8)>>3 (size is length-1). On mismatch, pulse nwr_err_o together with user_wr_last_o; nwr_pkt_cnt_o still increments.
- Undefined: size is ignored; nwr_err_o fires only on overrun or an empty NWR.

Decomposition:
Shared package rio_pkg holds:
- FTYPE_DOORB=4'hA, FTYPE_NWR=4'h5, TTYPE_NWR=4'h4.
- DB_SELF_CHECK=16'h0101, DB_READY=16'h0100, DB_BUSY=16'h01FF, DB_INTEG_BASE=16'h0200.
- Header field bit positions and the state enum.

No sub-module; header field extraction is inline. It is shared with the initiator only through the package.

Test Plan:
1. Doorbell tid=8'h00, info=0x0101, user_busy_in=0, tuser src=0x0012 -> one tresp beat with info 0x0100, ftype A, prio 2, tuser={8'h00,8'hF0,16'h0012}.
2. Same doorbell with user_busy_in=1 and tresp_tready_in held low 5 cycles -> info 0x01FF held stable, treq_tready_o=0 throughout, a single beat after release.
3. NWR header addr=34'h100000, size=8'h1F plus 4 payload beats, last with tlast -> user_wr_addr 0x100000/08/10/18, user_wr_last_o on the 4th beat, nwr_pkt_cnt_o=1, nwr_err_o=0.
4. Doorbell info=0x0201 -> db_info_valid_o pulse with db_info_o=0x0201, response info echoes 0x0201.
5. NWR with 33 payload beats -> nwr_err_o after the 32nd, the remaining beat dropped, FSM back in IDLE, nwr_pkt_cnt_o unchanged; with NWR_SIZE_CHECK_EN and size=8'h1F but 3 beats -> nwr_err_o on the last beat.
6. Assert log_rst during beat 2 of an NWR -> all outputs 0 asynchronously; a following doorbell is answered normally.

Source files
------------

// File: rtl/rio_pkg.sv
// Shared definitions for the doorbell/NWR self-check protocol. Used by both
// the target responder and the initiator.
package rio_pkg;

  localparam logic [3:0]  FTYPE_DOORB   = 4'hA;
  localparam logic [3:0]  FTYPE_NWR     = 4'h5;
  localparam logic [3:0]  TTYPE_NWR     = 4'h4;

  localparam logic [15:0] DB_SELF_CHECK = 16'h0101;
  localparam logic [15:0] DB_READY      = 16'h0100;
  localparam logic [15:0] DB_BUSY       = 16'h01FF;
  localparam logic [15:0] DB_INTEG_BASE = 16'h0200;

  // Header field LSB positions inside the 64-bit first beat
  localparam int unsigned HDR_TID_LSB   = 56;  // [63:56]
  localparam int unsigned HDR_FTYPE_LSB = 52;  // [55:52]
  localparam int unsigned HDR_TTYPE_LSB = 48;  // [51:48]
  localparam int unsigned HDR_PRIO_LSB  = 45;  // [46:45]
  localparam int unsigned HDR_SIZE_LSB  = 36;  // [43:36]
  localparam int unsigned HDR_INFO_LSB  = 16;  // [31:16]
  localparam int unsigned HDR_ADDR_W    = 34;  // [33:0]

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DB_RESP,
    ST_NWR_DATA,
    ST_DROP
  } state_t;

  // Doorbell info in the 0x02xx data-integration range
  function automatic logic db_is_integ(input logic [15:0] info);
    return (info[15:8] == DB_INTEG_BASE[15:8]);
  endfunction

  // Info field returned in the doorbell response
  function automatic logic [15:0] db_resp_info(input logic [15:0] info,
                                               input logic        busy);
    logic [15:0] r;
    if (info == DB_SELF_CHECK)
      r = busy ? DB_BUSY : DB_READY;
    else if (db_is_integ(info))
      r = info;
    else
      r = DB_BUSY;
    return r;
  endfunction

endpackage

// File: rtl/db_target_resp.sv
// Target-side responder: answers doorbells and unpacks NWR packets into a
// registered write stream. Optional build macro: NWR_SIZE_CHECK_EN checks
// the received beat count against the header size field.
module db_target_resp
  import rio_pkg::*;
#(
  parameter logic [7:0] DEV_ID    = 8'hF0,
  parameter int         MAX_BEATS = 32
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic        treq_tvalid_in,
  output logic        treq_tready_o,
  input  logic        treq_tlast_in,
  input  logic [63:0] treq_tdata_in,
  input  logic [7:0]  treq_tkeep_in,
  input  logic [31:0] treq_tuser_in,
  output logic        tresp_tvalid_o,
  input  logic        tresp_tready_in,
  output logic        tresp_tlast_o,
  output logic [63:0] tresp_tdata_o,
  output logic [7:0]  tresp_tkeep_o,
  output logic [31:0] tresp_tuser_o,
  input  logic        user_busy_in,
  output logic        user_wr_valid_o,
  output logic [33:0] user_wr_addr_o,
  output logic [63:0] user_wr_data_o,
  output logic [7:0]  user_wr_keep_o,
  output logic        user_wr_last_o,
  output logic        db_info_valid_o,
  output logic [15:0] db_info_o,
  output logic [15:0] nwr_pkt_cnt_o,
  output logic        nwr_err_o
);

  localparam logic [5:0] BEAT_LAST = 6'(MAX_BEATS - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_tready;
  logic [7:0]  r_tid;
  logic [1:0]  r_prio;
  logic [15:0] r_resp_info;
  logic [15:0] r_src_id;
  logic        r_db_info_valid;
  logic [15:0] r_db_info;
  logic [33:0] r_base;
  logic [5:0]  r_beat_cnt;
  logic        r_wr_valid;
  logic [33:0] r_wr_addr;
  logic [63:0] r_wr_data;
  logic [7:0]  r_wr_keep;
  logic        r_wr_last;
  logic [15:0] r_pkt_cnt;
  logic        r_err;
`ifdef NWR_SIZE_CHECK_EN
  logic [7:0]  r_size;
  logic [8:0]  w_exp_beats;
  logic [8:0]  w_rcv_beats;
`endif

  logic        w_hs;
  logic [3:0]  w_ftype;
  logic [3:0]  w_ttype;
  logic [7:0]  w_tid;
  logic [1:0]  w_prio;
  logic [15:0] w_info;
  logic [33:0] w_addr;
  logic        w_is_db;
  logic        w_is_nwr;
  logic        w_overflow;
  logic        w_resp_valid;
  logic        w_unused;

  assign w_hs     = treq_tvalid_in & r_tready;
  assign w_tid    = treq_tdata_in[HDR_TID_LSB+7:HDR_TID_LSB];
  assign w_ftype  = treq_tdata_in[HDR_FTYPE_LSB+3:HDR_FTYPE_LSB];
  assign w_ttype  = treq_tdata_in[HDR_TTYPE_LSB+3:HDR_TTYPE_LSB];
  assign w_prio   = treq_tdata_in[HDR_PRIO_LSB+1:HDR_PRIO_LSB];
  assign w_info   = treq_tdata_in[HDR_INFO_LSB+15:HDR_INFO_LSB];
  assign w_addr   = treq_tdata_in[HDR_ADDR_W-1:0];
  assign w_is_db  = (w_ftype == FTYPE_DOORB);
  assign w_is_nwr = (w_ftype == FTYPE_NWR) && (w_ttype == TTYPE_NWR);
  // A non-last beat landing on the final allowed payload slot
  assign w_overflow = !treq_tlast_in && (r_beat_cnt == BEAT_LAST);

`ifdef NWR_SIZE_CHECK_EN
  assign w_exp_beats = ({1'b0, r_size} + 9'd8) >> 3;
  assign w_rcv_beats = {3'b000, r_beat_cnt} + 9'd1;
`endif

  assign w_unused = ^{treq_tuser_in[15:0], treq_tdata_in[47], treq_tdata_in[44],
                      treq_tdata_in[43:36], treq_tdata_in[35:34]};

  assign w_resp_valid   = (r_state == ST_DB_RESP);
  assign treq_tready_o  = r_tready;
  assign tresp_tvalid_o = w_resp_valid;
  assign tresp_tlast_o  = w_resp_valid;
  assign tresp_tkeep_o  = w_resp_valid ? 8'hFF : '0;
  assign tresp_tdata_o  = w_resp_valid ?
    {r_tid, FTYPE_DOORB, 4'h0, 1'b0, r_prio + 2'd1, 1'b0, 12'h000, r_resp_info, 16'h0000} : '0;
  assign tresp_tuser_o  = w_resp_valid ? {8'h00, DEV_ID, r_src_id} : '0;

  assign user_wr_valid_o = r_wr_valid;
  assign user_wr_addr_o  = r_wr_addr;
  assign user_wr_data_o  = r_wr_data;
  assign user_wr_keep_o  = r_wr_keep;
  assign user_wr_last_o  = r_wr_last;
  assign db_info_valid_o = r_db_info_valid;
  assign db_info_o       = r_db_info;
  assign nwr_pkt_cnt_o   = r_pkt_cnt;
  assign nwr_err_o       = r_err;

  // State register
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode from the current beat and response handshake
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (w_is_db && treq_tlast_in)        w_next = ST_DB_RESP;
          else if (w_is_nwr && !treq_tlast_in) w_next = ST_NWR_DATA;
          else if (!treq_tlast_in)             w_next = ST_DROP;
          else                                 w_next = ST_IDLE;
        end
      end
      ST_DB_RESP: begin
        if (tresp_tready_in) w_next = ST_IDLE;
      end
      ST_NWR_DATA: begin
        if (w_hs) begin
          if (treq_tlast_in)   w_next = ST_IDLE;
          else if (w_overflow) w_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (w_hs && treq_tlast_in) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it is low in reset and
  // low for the whole time a doorbell response is pending.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) r_tready <= 1'b0;
    else         r_tready <= (w_next != ST_DB_RESP);
  end

  // Doorbell capture, NWR unpacking, counters and error pulses
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      r_tid           <= '0;
      r_prio          <= '0;
      r_resp_info     <= '0;
      r_src_id        <= '0;
      r_db_info_valid <= 1'b0;
      r_db_info       <= '0;
      r_base          <= '0;
      r_beat_cnt      <= '0;
      r_wr_valid      <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_wr_keep       <= '0;
      r_wr_last       <= 1'b0;
      r_pkt_cnt       <= '0;
      r_err           <= 1'b0;
`ifdef NWR_SIZE_CHECK_EN
      r_size          <= '0;
`endif
    end else begin
      r_db_info_valid <= 1'b0;
      r_wr_valid      <= 1'b0;
      r_err           <= 1'b0;
      if (w_hs) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_is_db && treq_tlast_in) begin
              r_tid       <= w_tid;
              r_prio      <= w_prio;
              r_src_id    <= treq_tuser_in[31:16];
              r_resp_info <= db_resp_info(w_info, user_busy_in);
              if (db_is_integ(w_info)) begin
                r_db_info_valid <= 1'b1;
                r_db_info       <= w_info;
              end
            end else if (w_is_nwr && !treq_tlast_in) begin
              r_base     <= w_addr;
              r_beat_cnt <= '0;
`ifdef NWR_SIZE_CHECK_EN
              r_size     <= treq_tdata_in[HDR_SIZE_LSB+7:HDR_SIZE_LSB];
`endif
            end else if (w_is_nwr && treq_tlast_in) begin
              r_err <= 1'b1;
            end
          end
          ST_NWR_DATA: begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_base + {25'd0, r_beat_cnt, 3'b000};
            r_wr_data  <= treq_tdata_in;
            r_wr_keep  <= treq_tkeep_in;
            r_wr_last  <= treq_tlast_in | w_overflow;
            r_beat_cnt <= r_beat_cnt + 6'd1;
            if (treq_tlast_in) begin
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
`ifdef NWR_SIZE_CHECK_EN
              if (w_rcv_beats != w_exp_beats) r_err <= 1'b1;
`endif
            end else if (w_overflow) begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_db_target_resp.sv
// Self-checking bench for db_target_resp: directed scenarios pinned with
// literal values, then randomized traffic checked against a queue model.
module tb_db_target_resp;

  logic        log_clk;
  logic        log_rst;
  logic        treq_tvalid_in;
  logic        treq_tready_o;
  logic        treq_tlast_in;
  logic [63:0] treq_tdata_in;
  logic [7:0]  treq_tkeep_in;
  logic [31:0] treq_tuser_in;
  logic        tresp_tvalid_o;
  logic        tresp_tready_in;
  logic        tresp_tlast_o;
  logic [63:0] tresp_tdata_o;
  logic [7:0]  tresp_tkeep_o;
  logic [31:0] tresp_tuser_o;
  logic        user_busy_in;
  logic        user_wr_valid_o;
  logic [33:0] user_wr_addr_o;
  logic [63:0] user_wr_data_o;
  logic [7:0]  user_wr_keep_o;
  logic        user_wr_last_o;
  logic        db_info_valid_o;
  logic [15:0] db_info_o;
  logic [15:0] nwr_pkt_cnt_o;
  logic        nwr_err_o;

  db_target_resp #(.DEV_ID(8'hF0), .MAX_BEATS(32)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .treq_tvalid_in(treq_tvalid_in), .treq_tready_o(treq_tready_o),
    .treq_tlast_in(treq_tlast_in), .treq_tdata_in(treq_tdata_in),
    .treq_tkeep_in(treq_tkeep_in), .treq_tuser_in(treq_tuser_in),
    .tresp_tvalid_o(tresp_tvalid_o), .tresp_tready_in(tresp_tready_in),
    .tresp_tlast_o(tresp_tlast_o), .tresp_tdata_o(tresp_tdata_o),
    .tresp_tkeep_o(tresp_tkeep_o), .tresp_tuser_o(tresp_tuser_o),
    .user_busy_in(user_busy_in),
    .user_wr_valid_o(user_wr_valid_o), .user_wr_addr_o(user_wr_addr_o),
    .user_wr_data_o(user_wr_data_o), .user_wr_keep_o(user_wr_keep_o),
    .user_wr_last_o(user_wr_last_o),
    .db_info_valid_o(db_info_valid_o), .db_info_o(db_info_o),
    .nwr_pkt_cnt_o(nwr_pkt_cnt_o), .nwr_err_o(nwr_err_o)
  );

  initial log_clk = 1'b0;
  always #5 log_clk = ~log_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [33:0] addr;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } wr_t;

  wr_t         exp_wr[$];
  logic [63:0] exp_rdata[$];
  logic [31:0] exp_ruser[$];
  logic [15:0] exp_info[$];
  int          exp_err   = 0;
  int          seen_err  = 0;
  int          exp_pkt   = 0;
  logic [63:0] last_rdata;
  logic [31:0] last_ruser;
  logic [15:0] last_info;
  logic [33:0] wr_log[$];
  int          rdy_mode  = 0;  // 0: always ready, 1: random, 2: held low

  function automatic logic [63:0] mk_hdr(input logic [7:0] tid, input logic [3:0] ft,
                                         input logic [3:0] tt, input logic [1:0] prio,
                                         input logic [7:0] size, input logic [33:0] addr);
    logic [63:0] h;
    h = '0;
    h[63:56] = tid; h[55:52] = ft; h[51:48] = tt;
    h[46:45] = prio; h[43:36] = size; h[33:0] = addr;
    return h;
  endfunction

  function automatic logic [15:0] model_info(input logic [15:0] info, input logic busy);
    if (info == 16'h0101) return busy ? 16'h01FF : 16'h0100;
    if (info >= 16'h0200 && info <= 16'h02FF) return info;
    return 16'h01FF;
  endfunction

  // ---------------- response ready driver ----------------
  always @(posedge log_clk) begin
    #1;
    if (rdy_mode == 0)      tresp_tready_in = 1'b1;
    else if (rdy_mode == 1) tresp_tready_in = 1'($urandom_range(0, 1));
    else                    tresp_tready_in = 1'b0;
  end

  // ---------------- compare process ----------------
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;

  always @(negedge log_clk) begin
    if (log_rst) begin
      seen_err   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("resp_hold_valid", 64'(tresp_tvalid_o), 64'd1);
        chk("resp_hold_data", tresp_tdata_o, prev_data);
      end
      if (tresp_tvalid_o) begin
        chk("treq_ready_in_resp", 64'(treq_tready_o), 64'd0);
        chk("resp_last_keep", {55'd0, tresp_tlast_o, tresp_tkeep_o}, {55'd0, 1'b1, 8'hFF});
        if (tresp_tready_in) begin
          if (exp_rdata.size() == 0) begin
            chk("resp_unexpected", 64'(tresp_tvalid_o), 64'd0);
          end else begin
            chk("resp_data", tresp_tdata_o, exp_rdata.pop_front());
            chk("resp_user", 64'(tresp_tuser_o), 64'(exp_ruser.pop_front()));
          end
          last_rdata = tresp_tdata_o;
          last_ruser = tresp_tuser_o;
        end
      end
      prev_stall = tresp_tvalid_o && !tresp_tready_in;
      prev_data  = tresp_tdata_o;
      if (user_wr_valid_o) begin
        wr_log.push_back(user_wr_addr_o);
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 64'(user_wr_valid_o), 64'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(user_wr_addr_o), 64'(e.addr));
          chk("wr_data", user_wr_data_o, e.data);
          chk("wr_keep_last", {55'd0, user_wr_keep_o, user_wr_last_o},
              {55'd0, e.keep, e.last});
        end
      end
      if (db_info_valid_o) begin
        last_info = db_info_o;
        if (exp_info.size() == 0) chk("info_unexpected", 64'(db_info_valid_o), 64'd0);
        else                      chk("db_info", 64'(db_info_o), 64'(exp_info.pop_front()));
      end
      if (nwr_err_o) begin
        seen_err++;
        if (user_wr_valid_o) chk("err_with_last", 64'(user_wr_last_o), 64'd1);
      end
      chk("err_count", 64'(seen_err), 64'(exp_err));
      chk("pkt_cnt", 64'(nwr_pkt_cnt_o), 64'(16'(exp_pkt)));
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic [31:0] u,
                           input logic l, output bit ok);
    int b;
    treq_tvalid_in = 1'b1;
    treq_tdata_in  = d;
    treq_tkeep_in  = k;
    treq_tuser_in  = u;
    treq_tlast_in  = l;
    b = 0;
    @(negedge log_clk);
    while (!treq_tready_o && b < 300) begin
      @(negedge log_clk);
      b++;
    end
    if (!treq_tready_o) begin
      chk("treq_timeout", 64'(treq_tready_o), 64'd1);
      ok = 1'b0;
    end else begin
      @(posedge log_clk);
      ok = 1'b1;
    end
    #1;
    treq_tvalid_in = 1'b0;
    treq_tlast_in  = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
      @(posedge log_clk); #1;
    end
  endtask

  task automatic do_doorbell(input logic [7:0] tid, input logic [1:0] prio,
                             input logic [15:0] info, input logic [15:0] src, input logic busy);
    logic [63:0] h;
    bit ok;
    user_busy_in = busy;
    h = mk_hdr(tid, 4'hA, 4'h0, prio, 8'h00, 34'd0);
    h[31:16] = info;
    send_beat(h, 8'hFF, {src, 16'h00F0}, 1'b1, ok);
    if (ok) begin
      exp_rdata.push_back({tid, 8'hA0, 1'b0, prio + 2'd1, 1'b0, 12'h000,
                           model_info(info, busy), 16'h0000});
      exp_ruser.push_back({8'h00, 8'hF0, src});
      if (info >= 16'h0200 && info <= 16'h02FF) exp_info.push_back(info);
    end
  endtask

  task automatic do_nwr(input logic [7:0] size, input logic [33:0] base, input int n);
    bit ok;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    send_beat(mk_hdr(8'($urandom), 4'h5, 4'h4, 2'($urandom), size, base), 8'hFF,
              $urandom, (n == 0), ok);
    if (!ok) return;
    if (n == 0) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < n; i++) begin
      gap();
      d = {$urandom, $urandom};
      k = 8'($urandom);
      l = (i == n - 1);
      send_beat(d, k, 32'd0, l, ok);
      if (!ok) return;
      if (i < 32) exp_wr.push_back('{base + 34'(8 * i), d, k, l || (i == 31 && n > 32)});
      if (i == 31 && n > 32) exp_err++;
      if (l && n <= 32) begin
        exp_pkt++;
`ifdef NWR_SIZE_CHECK_EN
        if (n != ((int'(size) + 8) >> 3)) exp_err++;
`endif
      end
    end
  endtask

  task automatic do_other(input int n0);
    logic [3:0] ft;
    logic [3:0] tt;
    int n;
    bit ok;
    ft = 4'($urandom);
    tt = 4'($urandom);
    n  = n0;
    if (ft == 4'h5 && tt == 4'h4) tt = 4'h1;
    if (ft == 4'hA && n < 2) n = 2;
    for (int i = 0; i < n; i++) begin
      send_beat((i == 0) ? mk_hdr(8'($urandom), ft, tt, 2'($urandom), 8'($urandom),
                                  34'($urandom)) : {$urandom, $urandom},
                8'hFF, $urandom, (i == n - 1), ok);
      if (!ok) return;
      gap();
    end
  endtask

  task automatic wait_quiet();
    int b;
    b = 0;
    while ((exp_rdata.size() != 0 || exp_wr.size() != 0 || tresp_tvalid_o) && b < 500) begin
      @(posedge log_clk); #1;
      b++;
    end
    repeat (2) begin @(posedge log_clk); #1; end
    chk("quiet_timeout", 64'(b < 500), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int b;
    bit ok;
    log_rst = 1'b1;
    treq_tvalid_in = 1'b0; treq_tlast_in = 1'b0; treq_tdata_in = '0;
    treq_tkeep_in = '0; treq_tuser_in = '0; user_busy_in = 1'b0;
    #12;
    chk("rst_ready", 64'(treq_tready_o), 64'd0);
    chk("rst_resp", {tresp_tvalid_o, tresp_tlast_o, tresp_tkeep_o, tresp_tuser_o},
        64'd0);
    chk("rst_wr", {user_wr_valid_o, user_wr_last_o, user_wr_keep_o, user_wr_addr_o}, 64'd0);
    chk("rst_misc", {db_info_valid_o, db_info_o, nwr_pkt_cnt_o, nwr_err_o}, 64'd0);
    @(posedge log_clk); #1;
    log_rst = 1'b0;

    // 1: self-check doorbell, not busy
    do_doorbell(8'h00, 2'd1, 16'h0101, 16'h0012, 1'b0);
    wait_quiet();
    chk("t1_rdata", last_rdata, 64'h00A0_4000_0100_0000);
    chk("t1_ruser", 64'(last_ruser), 64'h00F0_0012);

    // 2: busy, response held off for 5 cycles
    rdy_mode = 2;
    do_doorbell(8'h00, 2'd1, 16'h0101, 16'h0012, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge log_clk);
      chk("t2_valid", 64'(tresp_tvalid_o), 64'd1);
      chk("t2_ready", 64'(treq_tready_o), 64'd0);
      chk("t2_info", 64'(tresp_tdata_o[31:16]), 64'h01FF);
    end
    rdy_mode = 0;
    wait_quiet();
    chk("t2_rdata", last_rdata, 64'h00A0_4000_01FF_0000);

    // 3: four-beat NWR
    wr_log.delete();
    do_nwr(8'h1F, 34'h100000, 4);
    wait_quiet();
    chk("t3_nbeats", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      chk("t3_a0", 64'(wr_log[0]), 64'h100000);
      chk("t3_a1", 64'(wr_log[1]), 64'h100008);
      chk("t3_a2", 64'(wr_log[2]), 64'h100010);
      chk("t3_a3", 64'(wr_log[3]), 64'h100018);
    end
    chk("t3_pkt", 64'(nwr_pkt_cnt_o), 64'd1);
    chk("t3_err", 64'(seen_err), 64'd0);

    // 4: data-integration doorbell
    do_doorbell(8'h00, 2'd1, 16'h0201, 16'h0034, 1'b0);
    wait_quiet();
    chk("t4_info", 64'(last_info), 64'h0201);
    chk("t4_rdata", last_rdata, 64'h00A0_4000_0201_0000);

    // 5: 33-beat overrun
    do_nwr(8'hFF, 34'h3_FFFF_FF80, 33);
    wait_quiet();
    chk("t5_pkt", 64'(nwr_pkt_cnt_o), 64'd1);
    chk("t5_err", 64'(seen_err), 64'd1);
    do_doorbell(8'h55, 2'd3, 16'h1234, 16'h0001, 1'b0);
    wait_quiet();
    chk("t5_rdata", last_rdata, 64'h55A0_0000_01FF_0000);
`ifdef NWR_SIZE_CHECK_EN
    do_nwr(8'h1F, 34'h200, 3);
    wait_quiet();
    chk("t5_size_err", 64'(seen_err), 64'd2);
    chk("t5_size_pkt", 64'(nwr_pkt_cnt_o), 64'd2);
`endif

    // 6: asynchronous reset in the middle of an NWR payload
    send_beat(mk_hdr(8'h01, 4'h5, 4'h4, 2'd0, 8'h3F, 34'h4000), 8'hFF, 32'd0, 1'b0, ok);
    send_beat(64'h1111, 8'hFF, 32'd0, 1'b0, ok);
    exp_wr.push_back('{34'h4000, 64'h1111, 8'hFF, 1'b0});
    send_beat(64'h2222, 8'hFF, 32'd0, 1'b0, ok);
    #2;
    log_rst = 1'b1;
    #1;
    chk("t6_ready", 64'(treq_tready_o), 64'd0);
    chk("t6_wr", {user_wr_valid_o, user_wr_last_o, user_wr_keep_o, user_wr_addr_o}, 64'd0);
    chk("t6_wdata", user_wr_data_o, 64'd0);
    chk("t6_misc", {db_info_valid_o, db_info_o, nwr_pkt_cnt_o, nwr_err_o}, 64'd0);
    chk("t6_resp", {tresp_tvalid_o, tresp_tlast_o, tresp_tkeep_o, tresp_tuser_o}, 64'd0);
    exp_wr.delete(); exp_rdata.delete(); exp_ruser.delete(); exp_info.delete();
    exp_err = 0;
    exp_pkt = 0;
    @(posedge log_clk); @(posedge log_clk); #1;
    log_rst = 1'b0;
    do_doorbell(8'h7E, 2'd2, 16'h0101, 16'h00AB, 1'b0);
    wait_quiet();
    chk("t6_rdata", last_rdata, 64'h7EA0_6000_0100_0000);
    chk("t6_ruser", 64'(last_ruser), 64'h00F0_00AB);

    // randomized traffic
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      case ($urandom_range(0, 2))
        0: begin
          logic [15:0] info;
          case ($urandom_range(0, 2))
            0:       info = 16'h0101;
            1:       info = {8'h02, 8'($urandom)};
            default: info = 16'($urandom);
          endcase
          do_doorbell(8'($urandom), 2'($urandom), info, 16'($urandom), 1'($urandom));
        end
        1: begin
          if ($urandom_range(0, 7) == 0) n = $urandom_range(32, 35);
          else                           n = $urandom_range(0, 9);
          if (n >= 1 && n <= 32 && $urandom_range(0, 1) == 1)
            do_nwr(8'(8 * n - 1), {$urandom, 2'b00} + 34'($urandom), n);
          else
            do_nwr(8'($urandom), {$urandom, 2'b00} + 34'($urandom), n);
        end
        default: do_other($urandom_range(1, 4));
      endcase
      gap();
    end
    rdy_mode = 0;
    wait_quiet();
    b = exp_rdata.size() + exp_wr.size() + exp_info.size();
    chk("final_queues", 64'(b), 64'd0);
    chk("final_err", 64'(seen_err), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
